// File: rtl/crc_stream_engine_if.sv
// ----------------------------------------------------------------------------
// crc_stream_engine_if
//
// Purpose: groups the two handshake channels of the CRC stream engine.
//   Beat channel   (producer -> engine): s_valid, s_ready, s_data, s_keep, s_last
//   Result channel (engine -> consumer): m_valid, m_ready, m_crc, m_match, m_len
//
// Modports:
//   master : the side that feeds beats and consumes results (e.g. a testbench)
//   slave  : the CRC engine itself
//
// DATA_BYTES must match the DATA_BYTES of the engine it is connected to.
// ----------------------------------------------------------------------------
interface crc_stream_engine_if #(
    parameter int DATA_BYTES = 4
);
    logic                    s_valid;
    logic                    s_ready;
    logic [8*DATA_BYTES-1:0] s_data;
    logic [DATA_BYTES-1:0]   s_keep;
    logic                    s_last;

    logic                    m_valid;
    logic                    m_ready;
    logic [31:0]             m_crc;
    logic                    m_match;
    logic [15:0]             m_len;

    modport master (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_crc, m_match, m_len
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_crc, m_match, m_len
    );
endinterface

// File: rtl/crc_stream_engine.sv
// ----------------------------------------------------------------------------
// crc_stream_engine
//
// Purpose: computes a 32-bit CRC over a framed byte stream, DATA_BYTES bytes
// per beat, one beat per cycle. The result (CRC, residue match flag and the
// saturating byte count) is presented one cycle after the last beat and held
// until consumed.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous frame abort; wins over everything else
//   busy   out  frame open or result pending
//   bus    crc_stream_engine_if.slave (beat channel in, result channel out)
//
// Parameters: DATA_BYTES (1/2/4/8), CRC_POLY, CRC_INIT, XOR_OUT, REFLECT,
// CHECK_RESIDUE.
// ----------------------------------------------------------------------------
module crc_stream_engine #(
    parameter int          DATA_BYTES    = 4,
    parameter logic [31:0] CRC_POLY      = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT      = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT       = 32'hFFFFFFFF,
    parameter bit          REFLECT       = 1'b1,
    parameter logic [31:0] CHECK_RESIDUE = 32'h2144DF1C
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    output logic                   busy,
    crc_stream_engine_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] count_q, count_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_crc_q, m_crc_d;
    logic        m_match_q, m_match_d;
    logic [15:0] m_len_q, m_len_d;

    logic                  beat_fire;
    logic [DATA_BYTES-1:0] lane_en;
    logic [31:0]           beat_crc;
    logic [3:0]            lane_count;
    logic [16:0]           count_sum;
    logic [15:0]           beat_count;
    logic [31:0]           frame_crc;

    // The register is always kept in normal (MSB-first) form. Reflected
    // operation is obtained by bit-reversing each input byte going in and
    // the whole register coming out, so one update routine serves both modes.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
        logic [31:0] c;
        logic [7:0]  d;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            d[i] = REFLECT ? data[7-i] : data[i];
        end
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ d[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    assign bus.s_ready = !clr && (!m_valid_q || bus.m_ready);
    assign beat_fire   = bus.s_valid && bus.s_ready;

    // s_keep only matters on the last beat; earlier beats are always full.
    assign lane_en = bus.s_last ? bus.s_keep : {DATA_BYTES{1'b1}};

    // Fold every enabled lane into the CRC in ascending lane order within a
    // single cycle, and count how many bytes that was. Gaps in the keep mask
    // are simply skipped.
    always_comb begin
        beat_crc   = crc_q;
        lane_count = 4'd0;
        for (int lane = 0; lane < DATA_BYTES; lane++) begin
            if (lane_en[lane]) begin
                beat_crc   = crc_byte(beat_crc, bus.s_data[8*lane +: 8]);
                lane_count = lane_count + 4'd1;
            end
        end
    end

    // Byte count saturates at 16'hFFFF instead of wrapping so very long
    // frames still report a meaningful (clamped) length.
    assign count_sum  = {1'b0, count_q} + {13'd0, lane_count};
    assign beat_count = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    assign frame_crc  = (REFLECT ? reverse32(beat_crc) : beat_crc) ^ XOR_OUT;

    // Next-state logic. Priority: clr, then a beat transfer (which may also
    // be consuming the pending result in the same cycle), then a plain
    // result consume. A last beat always restarts the register so a new
    // frame may follow immediately with no idle cycle.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        count_d   = count_q;
        m_valid_d = m_valid_q;
        m_crc_d   = m_crc_q;
        m_match_d = m_match_q;
        m_len_d   = m_len_q;

        if (clr) begin
            state_d   = IDLE;
            crc_d     = CRC_INIT;
            count_d   = 16'd0;
            m_valid_d = 1'b0;
        end else if (beat_fire) begin
            if (bus.s_last) begin
                state_d   = DONE;
                crc_d     = CRC_INIT;
                count_d   = 16'd0;
                m_valid_d = 1'b1;
                m_crc_d   = frame_crc;
                m_match_d = (frame_crc == CHECK_RESIDUE);
                m_len_d   = beat_count;
            end else begin
                state_d   = ACCUM;
                crc_d     = beat_crc;
                count_d   = beat_count;
                m_valid_d = 1'b0;
            end
        end else if (m_valid_q && bus.m_ready) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
        end
    end

    // State and result registers; reset clears everything, including any
    // half-accumulated frame and any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= CRC_INIT;
            count_q   <= 16'd0;
            m_valid_q <= 1'b0;
            m_crc_q   <= 32'd0;
            m_match_q <= 1'b0;
            m_len_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_crc_q   <= m_crc_d;
            m_match_q <= m_match_d;
            m_len_q   <= m_len_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_crc   = m_crc_q;
    assign bus.m_match = m_match_q;
    assign bus.m_len   = m_len_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_crc_stream_engine.sv
// ----------------------------------------------------------------------------
// tb_crc_stream_engine
//
// Purpose: self-checking bench for crc_stream_engine. A default build
// (DATA_BYTES=4, CRC-32) is exercised with directed and random frames, and a
// DATA_BYTES=8 build with CRC-32/MPEG-2 settings is run on the check string.
// Expected results come from a byte-serial reference CRC over a queue of the
// bytes each frame should contain.
// ----------------------------------------------------------------------------
module tb_crc_stream_engine;

    typedef logic [7:0] byte_q_t[$];

    logic clk;
    logic rst_n;
    logic clr;
    logic busy;
    logic clr8;
    logic busy8;

    int compared;
    int mismatched;

    crc_stream_engine_if #(.DATA_BYTES(4)) bus ();
    crc_stream_engine_if #(.DATA_BYTES(8)) bus8 ();

    crc_stream_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .busy  (busy),
        .bus   (bus)
    );

    crc_stream_engine #(
        .DATA_BYTES (8),
        .REFLECT    (1'b0),
        .XOR_OUT    (32'h00000000)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr8),
        .busy  (busy8),
        .bus   (bus8)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Byte-serial reference CRC, written in the textbook form: the reflected
    // variant shifts right with the bit-reversed polynomial, the normal
    // variant shifts left.
    function automatic logic [31:0] crc_model(input byte_q_t q,
                                              input logic [31:0] poly,
                                              input logic [31:0] init,
                                              input logic [31:0] xo,
                                              input bit refl);
        logic [31:0] r;
        logic [31:0] p;
        if (refl) begin
            for (int i = 0; i < 32; i++) begin
                r[i] = init[31-i];
                p[i] = poly[31-i];
            end
            foreach (q[k]) begin
                r = r ^ {24'd0, q[k]};
                for (int b = 0; b < 8; b++) begin
                    r = r[0] ? ((r >> 1) ^ p) : (r >> 1);
                end
            end
        end else begin
            r = init;
            foreach (q[k]) begin
                r = r ^ {q[k], 24'd0};
                for (int b = 0; b < 8; b++) begin
                    r = r[31] ? ((r << 1) ^ poly) : (r << 1);
                end
            end
        end
        return r ^ xo;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one beat on the 4-byte engine and hold it until it transfers.
    // Inputs change on the falling edge so the next rising edge is the one
    // that samples them; returns just after the transfer edge.
    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep,
                                 input logic last);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.s_data  = data;
        bus.s_keep  = keep;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        #1;
        while (!bus.s_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.s_ready) begin
            checkOutput("beat_accept_timeout", 32'(bus.s_ready), 32'd1);
            bus.s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.s_valid = 1'b0;
        end
    endtask

    // Split a byte queue into full beats followed by one last beat whose
    // keep mask covers the remaining 0..4 bytes.
    task automatic send_bytes(input byte_q_t q);
        int          idx;
        logic [31:0] d;
        logic [3:0]  k;
        idx = 0;
        while (q.size() - idx > 4) begin
            d = {q[idx+3], q[idx+2], q[idx+1], q[idx]};
            applyStimulus(d, 4'hF, 1'b0);
            idx += 4;
        end
        d = '0;
        k = '0;
        for (int l = 0; l < 4; l++) begin
            if (idx + l < q.size()) begin
                d[8*l +: 8] = q[idx+l];
                k[l]        = 1'b1;
            end
        end
        applyStimulus(d, k, 1'b1);
    endtask

    // Called right after the last-beat transfer: the result must already be
    // valid on the following falling edge.
    task automatic expect_result(input string tag, input byte_q_t q);
        logic [31:0] e;
        int          len;
        e   = crc_model(q, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        len = (q.size() > 65535) ? 65535 : q.size();
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
        checkOutput({tag, "_crc"}, bus.m_crc, e);
        checkOutput({tag, "_len"}, 32'(bus.m_len), 32'(len));
        checkOutput({tag, "_match"}, 32'(bus.m_match), 32'(e == 32'h2144DF1C));
    endtask

    task automatic consume_result(input string tag);
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_released"}, 32'(bus.m_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        byte_q_t     check_str;
        byte_q_t     q;
        byte_q_t     q2;
        logic [31:0] d;
        logic [3:0]  k;
        int          nb;

        compared    = 0;
        mismatched  = 0;
        check_str   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        rst_n       = 1'b0;
        clr         = 1'b0;
        clr8        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_keep  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        bus8.s_valid = 1'b0;
        bus8.s_data  = '0;
        bus8.s_keep  = '0;
        bus8.s_last  = 1'b0;
        bus8.m_ready = 1'b0;

        // Reset values.
        #12;
        checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("rst_m_crc", bus.m_crc, 32'd0);
        checkOutput("rst_m_len", 32'(bus.m_len), 32'd0);
        checkOutput("rst_m_match", 32'(bus.m_match), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Standard check string, then the same bytes with their FCS appended.
        send_bytes(check_str);
        expect_result("check", check_str);
        checkOutput("check_const", bus.m_crc, 32'hCBF43926);
        consume_result("check");

        q = check_str;
        q.push_back(8'h26);
        q.push_back(8'h39);
        q.push_back(8'hF4);
        q.push_back(8'hCB);
        send_bytes(q);
        expect_result("fcs", q);
        checkOutput("fcs_match_const", 32'(bus.m_match), 32'd1);
        consume_result("fcs");

        // Empty frame: single last beat with nothing kept.
        q = {};
        applyStimulus($urandom, 4'h0, 1'b1);
        expect_result("empty", q);
        checkOutput("empty_const", bus.m_crc, 32'h00000000);
        consume_result("empty");

        // Result held under back-pressure, then released in the same cycle
        // that a new one-beat frame is accepted.
        send_bytes(check_str);
        expect_result("held", check_str);
        d  = $urandom;
        q2 = '{d[7:0], d[15:8], d[23:16], d[31:24]};
        bus.s_data  = d;
        bus.s_keep  = 4'hF;
        bus.s_last  = 1'b1;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_ready%0d", i), 32'(bus.s_ready), 32'd0);
            checkOutput($sformatf("stall_crc%0d", i), bus.m_crc, 32'hCBF43926);
        end
        bus.m_ready = 1'b1;
        #1;
        checkOutput("release_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        expect_result("back_to_back", q2);
        consume_result("back_to_back");

        // Random frames: random full beats (keep ignored) and a random,
        // possibly non-contiguous, keep mask on the last beat.
        for (int f = 0; f < 8; f++) begin
            q  = {};
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                d = $urandom;
                k = 4'($urandom_range(0, 15));
                for (int l = 0; l < 4; l++) q.push_back(d[8*l +: 8]);
                applyStimulus(d, k, 1'b0);
            end
            d = $urandom;
            k = 4'($urandom_range(0, 15));
            for (int l = 0; l < 4; l++) begin
                if (k[l]) q.push_back(d[8*l +: 8]);
            end
            applyStimulus(d, k, 1'b1);
            expect_result($sformatf("rand%0d", f), q);
            consume_result($sformatf("rand%0d", f));
        end

        // Abort mid-frame with clr, then a clean frame.
        applyStimulus($urandom, 4'hF, 1'b0);
        @(negedge clk);
        checkOutput("clr_busy_before", 32'(busy), 32'd1);
        clr         = 1'b1;
        bus.s_valid = 1'b1;
        #1;
        checkOutput("clr_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk);
        #1;
        clr         = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        checkOutput("clr_busy_after", 32'(busy), 32'd0);
        checkOutput("clr_m_valid", 32'(bus.m_valid), 32'd0);
        send_bytes(check_str);
        expect_result("after_clr", check_str);
        consume_result("after_clr");

        // clr discards a pending result.
        send_bytes(check_str);
        expect_result("pend", check_str);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        checkOutput("clr_pending_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("clr_pending_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-frame, then a clean frame.
        applyStimulus($urandom, 4'hF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("arst_m_crc", bus.m_crc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bytes(check_str);
        expect_result("after_rst", check_str);
        checkOutput("after_rst_const", bus.m_crc, 32'hCBF43926);
        consume_result("after_rst");

        // Length saturation on a frame longer than 65535 bytes.
        q = {};
        for (int i = 0; i < 65540; i++) q.push_back(8'($urandom));
        send_bytes(q);
        expect_result("saturate", q);
        checkOutput("saturate_const", 32'(bus.m_len), 32'h0000FFFF);
        consume_result("saturate");

        // Eight-byte build with CRC-32/MPEG-2 settings.
        @(negedge clk);
        bus8.s_data  = 64'h3837363534333231;
        bus8.s_keep  = 8'hFF;
        bus8.s_last  = 1'b0;
        bus8.s_valid = 1'b1;
        #1;
        checkOutput("wide_ready", 32'(bus8.s_ready), 32'd1);
        @(posedge clk);
        #1;
        bus8.s_data = 64'h0000000000000039;
        bus8.s_keep = 8'h01;
        bus8.s_last = 1'b1;
        @(posedge clk);
        #1;
        bus8.s_valid = 1'b0;
        @(negedge clk);
        checkOutput("wide_valid", 32'(bus8.m_valid), 32'd1);
        checkOutput("wide_crc", bus8.m_crc,
                    crc_model(check_str, 32'h04C11DB7, 32'hFFFFFFFF, 32'h0, 1'b0));
        checkOutput("wide_crc_const", bus8.m_crc, 32'h0376E6E7);
        checkOutput("wide_len", 32'(bus8.m_len), 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
